branch_predictor: RTL
=====================

# branch_predictor

Front-end direction predictor and branch target buffer that supplies `target_address_final` / `predict_final` to the next-PC selector in the PF stage. It is trained by branch resolutions from EX. It keeps running totals of resolved and mispredicted branches for performance counting. Lookup is combinational against registered tables; all state changes occur on the rising clock edge.

## Interface
- `IDX_W`, default 4: index width; table holds 2^IDX_W entries. Legal range 2..8.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `lookup_pc` in 32: PC being fetched in PF.
- `target_address_final` out 32: predicted next PC.
- `predict_final` out 1: 1 = predicted-taken BTB hit.
- `upd_valid` in 1: one resolved branch in EX this cycle. Driven as isBranch & ~stall.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: actual direction.
- `upd_target` in 32: actual taken target.
- `upd_predicted` in 1: `predict_final` value carried down with this branch.
- `upd_pred_target` in 32: `target_address_final` value carried down with this branch.
- `inv` in 1: invalidate the whole table.
- `br_total` out 32: count of resolved branches.
- `br_mispredict` out 32: count of mispredicted branches.

## Operation
- Entry fields: `valid`, `tag[31:IDX_W+2]`, `target[31:0]`, `ctr[1:0]` (2-bit saturating counter).
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Lookup (combinational):
  - hit = valid & tag match.
  - `predict_final` = hit & ctr[1].
  - `target_address_final` = `predict_final` ? target : `lookup_pc` + 4. The add is 32-bit and wraps, so 0xFFFFFFFC gives 0x00000000.
- Update, on an edge where `upd_valid`=1 and `inv`=0, using the entry at upd index:
  - Hit, taken: ctr = min(ctr+1, 3); target <= `upd_target`.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate the entry (overwriting any previous occupant): valid=1, tag, target=`upd_target`, ctr=2'b10.
  - Miss, not taken: no change.
- Mispredict (only when `upd_valid`=1): (`upd_predicted` != `upd_taken`) OR (`upd_predicted` & `upd_taken` & `upd_pred_target` != `upd_target`).
- `inv`=1: all valid bits clear at the next edge. ctr and target fields are unchanged. Any update in the same cycle is dropped from the table.
- Statistics are updated independently of `inv`:
  - `br_total` increments on every `upd_valid`.
  - `br_mispredict` increments when `upd_valid` and mispredict.
  - Both counters wrap modulo 2^32.

## Timing
- Reset (`rst`=0, asynchronous): all valid=0, all ctr=2'b01, all target=0, `br_total`=0, `br_mispredict`=0.
- Resulting outputs during and after reset: `predict_final`=0, `target_address_final`=`lookup_pc`+4.
- Reset asserted mid-update discards that update. Deassertion is synchronised externally.
- Lookup latency is 0 cycles; outputs settle in the same cycle as `lookup_pc`.
- Update latency is 1 cycle; the change is visible to lookups from the cycle after the update edge.
- Same cycle, same index for lookup and update: lookup sees pre-update contents. No bypass.
- One update per cycle maximum. No handshake: `upd_valid` is a single-cycle qualifier and the block is never busy.
- Aliasing: different PCs with the same index replace each other only on taken-miss allocation. A not-taken PC never evicts an entry.

## Test plan
- Reset: hold `rst`=0, `lookup_pc`=0x1C000000 → `predict_final`=0, `target_address_final`=0x1C000004, both counters 0. Release, no activity → outputs unchanged.
- Allocation: update pc=0x1C000010, taken, target=0x1C000100, predicted=0 → next cycle lookup 0x1C000010 gives predict=1, target=0x1C000100; `br_total`=1, `br_mispredict`=1.
- Hysteresis: from ctr=2 apply not-taken → ctr=1, lookup predicts 0 → `target_address_final`=pc+4. Two taken updates → ctr=3. Three not-taken → ctr=0. A fourth not-taken stays 0.
- Target mismatch: hit entry predicts 0x1C000100; resolve taken to 0x1C000200 with upd_pred_target=0x1C000100 → `br_mispredict` increments, next lookup target=0x1C000200.
- Same-cycle lookup and update on one index: lookup in the update cycle shows old values, the following cycle shows new ones. Tag alias 0x1C000010 vs 0x1C000050 (IDX_W=4): lookup of the alias misses; a taken-miss update on the alias replaces the entry.
- `inv` together with `upd_valid` (taken-miss) → next cycle all lookups miss, no allocation happened, `br_total` still increments. Wrap: preset `br_total`=0xFFFFFFFF, one update → 0. Lookup at 0xFFFFFFFC miss → 0x00000000.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Lookup, training and statistics signals between the fetch/execute pipeline and the branch predictor.
// upd_valid is a single-cycle qualifier with no ready: the predictor is never busy, so every cycle with upd_valid=1 is consumed on that clock edge.
interface branch_predictor_if;
  logic [31:0] lookup_pc;
  logic [31:0] target_address_final;
  logic        predict_final;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_predicted;
  logic [31:0] upd_pred_target;
  logic        inv;
  logic [31:0] br_total;
  logic [31:0] br_mispredict;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_predicted, upd_pred_target, inv,
    input  target_address_final, predict_final, br_total, br_mispredict
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_predicted, upd_pred_target, inv,
    output target_address_final, predict_final, br_total, br_mispredict
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational lookup,
// single-edge training from EX and running branch / mispredict totals.
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input logic clk,
    input logic rst,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        total_q;
    logic [31:0]        mis_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_ctr;
    logic             mispredict;
    logic             unused_pc_bits;

    // Word-aligned PCs: the low two bits never take part in index or tag.
    assign unused_pc_bits = &{1'b0, bp.lookup_pc[1:0], bp.upd_pc[1:0]};

    assign lk_idx = bp.lookup_pc[IDX_W+1:2];
    assign lk_tag = bp.lookup_pc[31:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign bp.predict_final        = lk_hit & ctr_q[lk_idx][1];
    assign bp.target_address_final = bp.predict_final ? target_q[lk_idx]
                                                      : bp.lookup_pc + 32'd4;

    assign up_idx = bp.upd_pc[IDX_W+1:2];
    assign up_tag = bp.upd_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        up_ctr = ctr_q[up_idx];
        if (bp.upd_taken) begin
            if (ctr_q[up_idx] != 2'b11) up_ctr = ctr_q[up_idx] + 2'd1;
        end else begin
            if (ctr_q[up_idx] != 2'b00) up_ctr = ctr_q[up_idx] - 2'd1;
        end
    end

    // A taken branch predicted taken still mispredicts if it went somewhere else.
    assign mispredict = (bp.upd_predicted != bp.upd_taken) ||
                        (bp.upd_predicted && bp.upd_taken &&
                         (bp.upd_pred_target != bp.upd_target));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            total_q <= '0;
            mis_q   <= '0;
        end else begin
            if (bp.inv) begin
                valid_q <= '0;
            end else if (bp.upd_valid) begin
                if (up_hit) begin
                    ctr_q[up_idx] <= up_ctr;
                    if (bp.upd_taken) target_q[up_idx] <= bp.upd_target;
                end else if (bp.upd_taken) begin
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= bp.upd_target;
                    ctr_q[up_idx]    <= 2'b10;
                end
            end
            // Statistics keep counting even while the table is being flushed.
            if (bp.upd_valid) begin
                total_q <= total_q + 32'd1;
                if (mispredict) mis_q <= mis_q + 32'd1;
            end
        end
    end

    assign bp.br_total      = total_q;
    assign bp.br_mispredict = mis_q;
endmodule
